// File: rtl/rv_pkg.sv
// Shared RV definitions: default datapath width, register index width
// and the conditional-branch funct3 encodings.
package rv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch resolution: turns funct3 plus the zero / less-than flags into a
// taken decision, flagging the unassigned funct3 codes as illegal.
module branch_cmp
  import rv_pkg::*;
(
  input  logic       is_branch,
  input  logic [2:0] br_funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken,
  output logic       illegal
);

  logic cond;
  logic bad_code;

  // Decode the comparison selected by funct3
  always_comb begin
    cond     = 1'b0;
    bad_code = 1'b0;
    case (br_funct3)
      BEQ:     cond = zero;
      BNE:     cond = !zero;
      BLT:     cond = lt;
      BGE:     cond = !lt;
      BLTU:    cond = lt;
      BGEU:    cond = !lt;
      default: bad_code = 1'b1;
    endcase
    taken   = is_branch && cond && !bad_code;
    illegal = is_branch && bad_code;
  end

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: resolves branches and registers the ALU result towards
// writeback behind a valid/ready handshake.
// Build option: EX_RESULT_SKID_EN selects a 2-entry skid buffer with a
// registered in_ready; otherwise a single output register with a
// combinational in_ready.
module ex_result_stage
  import rv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [1:0]           status,
  input  logic                 is_branch,
  input  logic [2:0]           br_funct3,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     imm,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 rd_we,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_we,
  output logic                 out_br_taken,
  output logic [WIDTH-1:0]     out_br_target,
  output logic                 out_br_illegal
);

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_we;
    logic                 br_taken;
    logic [WIDTH-1:0]     br_target;
    logic                 br_illegal;
  } entry_t;

  logic   zero;
  logic   br_taken;
  logic   br_illegal;
  logic   status_unused;
  entry_t in_entry;
  entry_t head;
  logic   push;
  logic   pop;

  // status[0] carries a zero flag from the ALU that is deliberately not trusted
  assign status_unused = status[0];
  assign zero          = (alu_out == '0);

  branch_cmp u_branch_cmp (
    .is_branch (is_branch),
    .br_funct3 (br_funct3),
    .zero      (zero),
    .lt        (status[1]),
    .taken     (br_taken),
    .illegal   (br_illegal)
  );

  // Assemble the entry as it will be presented downstream
  always_comb begin
    in_entry            = '0;
    in_entry.result     = alu_out;
    in_entry.rd         = rd;
    in_entry.rd_we      = rd_we && !is_branch;
    in_entry.br_taken   = br_taken;
    in_entry.br_target  = is_branch ? (pc + imm) : '0;
    in_entry.br_illegal = br_illegal;
  end

`ifdef EX_RESULT_SKID_EN

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       ready_q;

  assign push     = in_valid && ready_q;
  assign pop      = (count != 2'd0) && out_ready;
  assign in_ready = ready_q;
  assign head     = mem[rd_ptr];

  // Next occupancy from this cycle's push/pop
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (pop && !push) begin
      count_nxt = count - 2'd1;
    end
  end

  // in_ready is registered from the next occupancy so it never depends on out_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count   <= count_nxt;
      ready_q <= (count_nxt < 2'd2);
    end
  end

  assign out_valid = (count != 2'd0);

`else

  logic   valid_q;
  entry_t ent_q;

  assign in_ready = !valid_q || out_ready;
  assign push     = in_valid && in_ready;
  assign pop      = valid_q && out_ready;
  assign head     = ent_q;

  // Single output register; a push on a popping cycle refills it with no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
      ent_q   <= in_entry;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;

`endif

  assign out_result     = head.result;
  assign out_rd         = head.rd;
  assign out_rd_we      = head.rd_we;
  assign out_br_taken   = head.br_taken;
  assign out_br_target  = head.br_target;
  assign out_br_illegal = head.br_illegal;

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands, result and PC.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream ALU result and sideband valid this cycle.
REQ-005 Port: in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 Port: alu_out  input  WIDTH  ALU result.
REQ-007 Port: status  input  2  ALU flags; bit1 = carry/less-than, bit0 unused here.
REQ-008 Port: is_branch  input  1  instruction is a conditional branch.
REQ-009 Port: br_funct3  input  3  RISC-V branch funct3.
REQ-010 Port: pc, imm  input  WIDTH each  instruction PC and sign-extended B-immediate.
REQ-011 Port: rd  input  5; rd_we  input  1  destination register and write enable.
REQ-012 Port: flush  input  1  discard all held and incoming entries.
REQ-013 Port: out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-014 Port: out_result  output  WIDTH; out_rd  output  5; out_rd_we  output  1.
REQ-015 Port: out_br_taken  output  1; out_br_target  output  WIDTH; out_br_illegal  output  1.

Function
REQ-016 Accepted entry appears at outputs exactly 1 cycle after acceptance when stage was empty.
REQ-017 Zero flag SHALL be recomputed locally as (alu_out == 0); status[0] SHALL be ignored.
REQ-018 Decision: 000 BEQ zero; 001 BNE !zero; 100 BLT status[1]; 101 BGE !status[1]; 110 BLTU status[1]; 111 BGEU !status[1].
REQ-019 funct3 010/011 with is_branch=1: out_br_taken=0, out_br_illegal=1 for that entry.
REQ-020 is_branch=0: out_br_taken=0, out_br_illegal=0, out_br_target=0.
REQ-021 out_br_target = pc + imm, truncated to WIDTH bits (wraps modulo 2^WIDTH).
REQ-022 Branch entries force out_rd_we=0 regardless of rd_we.
REQ-023 Output entry held stable while out_valid && !out_ready.
REQ-024 Same-cycle push and pop on full single-entry occupancy: pop and push both occur, no bubble.
REQ-025 Entries leave strictly in acceptance order; no drop, no duplication.
REQ-026 flush: all entries invalidated next edge; input in flush cycle discarded; flush wins over push/pop.

Reset
REQ-027 rst asserted: out_valid=0, out_result=0, out_rd=0, out_rd_we=0, out_br_taken=0, out_br_target=0, out_br_illegal=0, occupancy=0.
REQ-028 in_ready=1 from first edge after rst deassert; rst mid-transfer discards the entry.

Configuration
REQ-029 Macro EX_RESULT_SKID_EN defined: 2-entry skid buffer; in_ready registered, = (occupancy < 2), independent of out_ready combinationally.
REQ-030 Macro undefined: single register; in_ready = !out_valid || out_ready (combinational); all other behaviour identical.

Structure
REQ-031 Shared package rv_pkg holds WIDTH default, register index width (5), and branch funct3 constants BEQ..BGEU.
REQ-032 Combinational sub-module branch_cmp computes taken/illegal from is_branch, br_funct3, zero, status[1].

Verification
REQ-033 BEQ, alu_out=0 -> next cycle out_valid=1, out_br_taken=1, out_br_target=pc+imm, out_rd_we=0.
REQ-034 BLTU, status[1]=1, pc=0xFFFFFFFC, imm=8 -> out_br_taken=1, out_br_target=0x00000004.
REQ-035 is_branch=1, funct3=010 -> out_br_illegal=1, out_br_taken=0.
REQ-036 Non-branch alu_out=0x1234, rd=5, rd_we=1, out_ready low 3 cycles -> outputs stable, single delivery when out_ready rises.
REQ-037 EX_RESULT_SKID_EN, out_ready=0, push 2 -> in_ready=0 after second; third held; release drains in order.
REQ-038 flush with 2 held plus valid input -> next cycle out_valid=0, in_ready=1, nothing delivered.
